// File: rtl/reset_sequencer.sv
// Staged reset release for the PLL-derived fabric clock domain.
// The block waits for the synchronized PLL lock to stay high for a fixed interval.
// It then releases rst_out one bit at a time, lowest bit first.
// Losing lock, or a soft reset request, re-asserts every output on the next edge.
module reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1250,
  parameter int unsigned STAGE_GAP_CYCLES   = 16,
  parameter int unsigned NUM_STAGES         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_ready,
  output logic [7:0]            lock_lost_count
);

  localparam int unsigned StabW  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned GapW   = $clog2(STAGE_GAP_CYCLES + 1);
  localparam int unsigned StageW = $clog2(NUM_STAGES + 1);

  localparam logic [StabW-1:0]      StabLast  = StabW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GapW-1:0]       GapLast   = GapW'(STAGE_GAP_CYCLES - 1);
  localparam logic [StageW-1:0]     StageLast = StageW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] AllOnes   = {NUM_STAGES{1'b1}};

  typedef enum logic [1:0] {StWaitLock, StStabilize, StRelease, StRun} state_e;

  state_e                state_q, state_d;
  logic [StabW-1:0]      stab_cnt_q, stab_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [StageW-1:0]     stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  all_ready_q, all_ready_d;
  logic [7:0]            lost_cnt_q, lost_cnt_d;
  logic                  sync1_q, sync2_q;
  logic                  lock_sync;
  logic                  active;

  assign lock_sync = sync2_q;
  assign active    = (state_q == StRelease) || (state_q == StRun);

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and registered-output logic for the release sequence.
  always_comb begin
    state_d     = state_q;
    stab_cnt_d  = stab_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_d     = stage_q;
    rst_out_d   = rst_out_q;
    all_ready_d = all_ready_q;
    lost_cnt_d  = lost_cnt_q;

    if (active && !lock_sync) begin
      // A lock loss takes priority over a soft reset request on the same edge.
      state_d     = StWaitLock;
      rst_out_d   = AllOnes;
      all_ready_d = 1'b0;
      if (lost_cnt_q != 8'hFF) begin
        lost_cnt_d = lost_cnt_q + 8'd1;
      end
    end else if (active && soft_rst_req) begin
      state_d     = StStabilize;
      stab_cnt_d  = '0;
      rst_out_d   = AllOnes;
      all_ready_d = 1'b0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          rst_out_d   = AllOnes;
          all_ready_d = 1'b0;
          if (lock_sync) begin
            state_d    = StStabilize;
            stab_cnt_d = '0;
          end
        end
        StStabilize: begin
          if (!lock_sync) begin
            state_d = StWaitLock;
          end else if (stab_cnt_q == StabLast) begin
            // Bit 0 clears on the edge that enters the release phase.
            state_d   = StRelease;
            rst_out_d = AllOnes << 1;
            gap_cnt_d = '0;
            stage_d   = StageW'(1);
            if (NUM_STAGES == 1) begin
              state_d     = StRun;
              all_ready_d = 1'b1;
            end
          end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (gap_cnt_q == GapLast) begin
            // Bits clear in order, so shifting in a zero clears the next one.
            gap_cnt_d = '0;
            rst_out_d = rst_out_q << 1;
            stage_d   = stage_q + 1'b1;
            if (stage_q == StageLast) begin
              state_d     = StRun;
              all_ready_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        StRun: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitLock;
      stab_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stage_q     <= '0;
      rst_out_q   <= AllOnes;
      all_ready_q <= 1'b0;
      lost_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_q     <= stage_d;
      rst_out_q   <= rst_out_d;
      all_ready_q <= all_ready_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign rst_out         = rst_out_q;
  assign all_ready       = all_ready_q;
  assign lock_lost_count = lost_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, NUM_STAGES=3.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       soft_rst_req;
  logic [2:0] rst_out;
  logic       all_ready;
  logic [7:0] lock_lost_count;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP_CYCLES  (4),
    .NUM_STAGES        (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_lock       (pll_lock),
    .soft_rst_req   (soft_rst_req),
    .rst_out        (rst_out),
    .all_ready      (all_ready),
    .lock_lost_count(lock_lost_count)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // One edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lock goes high; the first edge is E0. rst_out[0] clears at E10, [1] at E14, [2] at E18.
  task automatic bringup(input string tag);
    logic [2:0] exp_v;
    pll_lock = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      exp_v = (e < 10) ? 3'b111 : (e < 14) ? 3'b110 : (e < 18) ? 3'b100 : 3'b000;
      chk($sformatf("%s_rst_out_E%0d", tag, e), {29'd0, rst_out}, {29'd0, exp_v});
      chk($sformatf("%s_ready_E%0d", tag, e), {31'd0, all_ready}, {31'd0, (e >= 18)});
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;
    rst          = 1'b1;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    repeat (4) tick();
    chk("reset_rst_out", {29'd0, rst_out}, 32'h7);
    chk("reset_ready", {31'd0, all_ready}, 32'h0);
    chk("reset_count", {24'd0, lock_lost_count}, 32'h0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_rst_out", {29'd0, rst_out}, 32'h7);

    // Nominal bring-up.
    bringup("nominal");
    chk("nominal_count", {24'd0, lock_lost_count}, 32'h0);

    // Lock loss in RUN: drop sampled at F, outputs re-asserted after F+2.
    pll_lock = 1'b0;
    tick();
    tick();
    chk("loss_F1_rst_out", {29'd0, rst_out}, 32'h0);
    tick();
    chk("loss_F2_rst_out", {29'd0, rst_out}, 32'h7);
    chk("loss_F2_ready", {31'd0, all_ready}, 32'h0);
    chk("loss_F2_count", {24'd0, lock_lost_count}, 32'h1);
    repeat (3) tick();
    chk("loss_hold_rst_out", {29'd0, rst_out}, 32'h7);
    bringup("relock");

    // Soft reset in RUN at edge S.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("soft_S_rst_out", {29'd0, rst_out}, 32'h7);
    chk("soft_S_ready", {31'd0, all_ready}, 32'h0);
    repeat (7) tick();
    chk("soft_S7_rst_out", {29'd0, rst_out}, 32'h7);
    tick();
    chk("soft_S8_rst_out", {29'd0, rst_out}, 32'h6);
    repeat (4) tick();
    chk("soft_S12_rst_out", {29'd0, rst_out}, 32'h4);
    repeat (4) tick();
    chk("soft_S16_rst_out", {29'd0, rst_out}, 32'h0);
    chk("soft_S16_ready", {31'd0, all_ready}, 32'h1);
    chk("soft_count", {24'd0, lock_lost_count}, 32'h1);

    // Unstable lock: high E0..E4, low at E5, re-sampled high at E6.
    pll_lock = 1'b0;
    repeat (4) tick();
    chk("drop2_count", {24'd0, lock_lost_count}, 32'h2);
    chk("drop2_rst_out", {29'd0, rst_out}, 32'h7);
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    chk("glitch_E6_rst_out", {29'd0, rst_out}, 32'h7);
    repeat (9) tick();
    chk("glitch_E15_rst_out", {29'd0, rst_out}, 32'h7);
    tick();
    chk("glitch_E16_rst_out", {29'd0, rst_out}, 32'h6);
    repeat (4) tick();
    chk("glitch_E20_rst_out", {29'd0, rst_out}, 32'h4);
    repeat (4) tick();
    chk("glitch_E24_rst_out", {29'd0, rst_out}, 32'h0);
    chk("glitch_E24_ready", {31'd0, all_ready}, 32'h1);

    // Lock loss and soft reset on the same edge while in RELEASE.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    repeat (8) tick();
    chk("sim_release_rst_out", {29'd0, rst_out}, 32'h6);
    pll_lock = 1'b0;
    tick();
    tick();
    chk("sim_F1_rst_out", {29'd0, rst_out}, 32'h6);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("sim_F2_rst_out", {29'd0, rst_out}, 32'h7);
    chk("sim_F2_ready", {31'd0, all_ready}, 32'h0);
    chk("sim_F2_count", {24'd0, lock_lost_count}, 32'h3);
    repeat (20) tick();
    chk("sim_hold_rst_out", {29'd0, rst_out}, 32'h7);
    chk("sim_hold_ready", {31'd0, all_ready}, 32'h0);
    chk("sim_hold_count", {24'd0, lock_lost_count}, 32'h3);

    // Saturation: 300 losses, each taken from RUN.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      repeat (19) tick();
      chk($sformatf("sat_ready_%0d", i), {31'd0, all_ready}, 32'h1);
      pll_lock = 1'b0;
      repeat (3) tick();
      exp_cnt = (i + 4 > 255) ? 8'd255 : 8'(i + 4);
      chk($sformatf("sat_count_%0d", i), {24'd0, lock_lost_count}, {24'd0, exp_cnt});
    end

    // Reset from RUN restores every reset value, including the synchronizer.
    pll_lock = 1'b1;
    repeat (19) tick();
    chk("pre_rst_ready", {31'd0, all_ready}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rst_out", {29'd0, rst_out}, 32'h7);
    chk("rst_ready", {31'd0, all_ready}, 32'h0);
    chk("rst_count", {24'd0, lock_lost_count}, 32'h0);
    bringup("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
